cordic_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `cordic` core among `NUM_REQ` requesters. It accepts one angle at a time from a requester, pulses the core's `start`, and holds `angle_in` stable while the core computes. After a fixed latency it captures `cos_out`/`sin_out` and returns them with the requester ID over a valid/ready response port. It sits between the angle-producing blocks and the single `cordic` instance.

---
 rtl/cordic_arbiter.sv | 131 +++++++++++++
 tb/tb_cordic_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// Round-robin front end for a single shared CORDIC core: grants one requester at a time,
// sequences the core through a fixed latency and returns the result with the owner's ID.
module cordic_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int WIDTH          = 32,
   parameter int CORDIC_LATENCY = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_angle,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   output logic [2:0]               rsp_id,
   output logic [WIDTH-1:0]         rsp_cos,
   output logic [WIDTH-1:0]         rsp_sin,
   input  logic                     rsp_ready,
   output logic                     busy,
   output logic                     cordic_start,
   output logic [WIDTH-1:0]         cordic_angle,
   input  logic [WIDTH-1:0]         cordic_cos,
   input  logic [WIDTH-1:0]         cordic_sin
);

   // state  | meaning
   // IDLE   | arbitrating; req_ready one-hot to the winner
   // ISSUE  | cordic_start pulse, wait counter loaded
   // WAIT   | core computing; capture results when counter hits 0
   // RESP   | result presented until rsp_ready

   localparam int CNT_W = (CORDIC_LATENCY > 1) ? $clog2(CORDIC_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORDIC_LATENCY - 1);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [2:0] LAST_ID = 3'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           state, state_nxt;
   logic [2:0]       rr_ptr;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       win_idx;
   logic             win_found;
   logic             accept;

   // Scan from the highest offset down so the closest requester above rr_ptr wins.
   always_comb begin
      int j;
      j         = 0;
      win_found = 1'b0;
      win_idx   = 3'd0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (req_valid[j[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = 3'(j);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == S_IDLE && win_found && !reset) req_ready[win_idx[IDX_W-1:0]] = 1'b1;
   end

   assign accept = |req_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      cordic_start = 1'b0;
      rsp_valid    = 1'b0;
      busy         = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (accept) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            cordic_start = 1'b1;
            state_nxt    = S_WAIT;
         end
         S_WAIT: begin
            if (cnt == '0) state_nxt = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr       <= 3'd0;
         cnt          <= '0;
         rsp_id       <= 3'd0;
         rsp_cos      <= '0;
         rsp_sin      <= '0;
         cordic_angle <= '0;
      end else begin
         if (accept) begin
            cordic_angle <= req_angle[int'(win_idx)*WIDTH +: WIDTH];
            rsp_id       <= win_idx;
         end
         if (state == S_ISSUE) cnt <= CNT_LOAD;
         if (state == S_WAIT) begin
            if (cnt == '0) begin
               rsp_cos <= cordic_cos;
               rsp_sin <= cordic_sin;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
         // Pointer moves only when a response is consumed.
         if (state == S_RESP && rsp_ready)
            rr_ptr <= (rsp_id == LAST_ID) ? 3'd0 : rsp_id + 3'd1;
      end
   end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter: two instances (latency 16 and 1), each driving
// a stub core that returns cos=angle, sin=~angle after the configured latency.
module tb_cordic_arbiter;

   localparam int N = 4;
   localparam int W = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // latency-16 instance
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_angle = '0;
   logic [N-1:0]   req_ready;
   logic           rsp_valid, busy, cordic_start, rsp_ready = 1'b0;
   logic [2:0]     rsp_id;
   logic [W-1:0]   rsp_cos, rsp_sin, cordic_angle, cordic_cos, cordic_sin;

   // latency-1 instance
   logic [N-1:0]   req_valid1 = '0;
   logic [N*W-1:0] req_angle1 = '0;
   logic [N-1:0]   req_ready1;
   logic           rsp_valid1, busy1, cordic_start1, rsp_ready1 = 1'b0;
   logic [2:0]     rsp_id1;
   logic [W-1:0]   rsp_cos1, rsp_sin1, cordic_angle1, cordic_cos1, cordic_sin1;

   cordic_arbiter #(.NUM_REQ(N), .WIDTH(W), .CORDIC_LATENCY(16)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_angle(req_angle),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_cos(rsp_cos),
      .rsp_sin(rsp_sin), .rsp_ready(rsp_ready), .busy(busy), .cordic_start(cordic_start),
      .cordic_angle(cordic_angle), .cordic_cos(cordic_cos), .cordic_sin(cordic_sin));

   cordic_arbiter #(.NUM_REQ(N), .WIDTH(W), .CORDIC_LATENCY(1)) dut1 (
      .clock(clock), .reset(reset), .req_valid(req_valid1), .req_angle(req_angle1),
      .req_ready(req_ready1), .rsp_valid(rsp_valid1), .rsp_id(rsp_id1), .rsp_cos(rsp_cos1),
      .rsp_sin(rsp_sin1), .rsp_ready(rsp_ready1), .busy(busy1), .cordic_start(cordic_start1),
      .cordic_angle(cordic_angle1), .cordic_cos(cordic_cos1), .cordic_sin(cordic_sin1));

   // Stub cores: results are only valid in the cycle before the capture edge.
   logic     core_busy = 1'b0, core_busy1 = 1'b0;
   int       core_cnt = 0, core_cnt1 = 0;
   logic [W-1:0] core_ang = '0, core_ang1 = '0;
   int       overlaps = 0;

   always @(posedge clock) begin
      if (cordic_start) begin
         if (core_busy) overlaps <= overlaps + 1;
         core_busy <= 1'b1;
         core_cnt  <= 15;
         core_ang  <= cordic_angle;
      end else if (core_busy) begin
         if (core_cnt == 0) core_busy <= 1'b0;
         else               core_cnt  <= core_cnt - 1;
      end
      if (cordic_start1) begin
         if (core_busy1) overlaps <= overlaps + 1;
         core_busy1 <= 1'b1;
         core_cnt1  <= 0;
         core_ang1  <= cordic_angle1;
      end else if (core_busy1) begin
         if (core_cnt1 == 0) core_busy1 <= 1'b0;
         else                core_cnt1  <= core_cnt1 - 1;
      end
   end

   assign cordic_cos  = (core_busy && core_cnt == 0)   ? core_ang    : 32'h0bad0bad;
   assign cordic_sin  = (core_busy && core_cnt == 0)   ? ~core_ang   : 32'h0bad0bad;
   assign cordic_cos1 = (core_busy1 && core_cnt1 == 0) ? core_ang1   : 32'h0bad0bad;
   assign cordic_sin1 = (core_busy1 && core_cnt1 == 0) ? ~core_ang1  : 32'h0bad0bad;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_grant(output int n, output logic [N-1:0] g);
      n = 0;
      while (req_ready == '0 && n < 60) begin
         tick();
         n++;
      end
      g = req_ready;
   endtask

   int           n;
   logic [N-1:0] g;
   logic         bad;
   logic [W-1:0] exp_grant;

   initial begin
      req_angle[0*W +: W] = 32'h11111111;
      req_angle[1*W +: W] = 32'h22222222;
      req_angle[2*W +: W] = 32'hc0000000;
      req_angle[3*W +: W] = 32'h40000000;
      req_valid = 4'b1111;
      #2;
      chk("rst_req_ready", req_ready, 4'b0000);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_start", cordic_start, 0);
      chk("rst_outs", {rsp_id, rsp_cos, rsp_sin, cordic_angle}, 0);
      req_valid = '0;
      tick();
      reset = 1'b0;
      tick();

      // single request from requester 2, then backpressure
      req_valid = 4'b0100;
      #1;
      chk("single_ready", req_ready, 4'b0100);
      tick();                       // cycle 1
      req_valid = '0;
      chk("single_start", cordic_start, 1);
      chk("single_angle", cordic_angle, 32'hc0000000);
      tick();                       // cycle 2
      chk("single_start_once", cordic_start, 0);
      repeat (15) tick();           // cycle 17
      chk("single_not_early", rsp_valid, 0);
      tick();                       // cycle 18
      chk("single_rsp_valid", rsp_valid, 1);
      chk("single_rsp_id", rsp_id, 3'd2);
      chk("single_rsp_cos", rsp_cos, 32'hc0000000);
      chk("single_rsp_sin", rsp_sin, 32'h3fffffff);

      req_valid = 4'b1011;
      #1;
      bad = 1'b0;
      repeat (10) begin
         if (!rsp_valid || rsp_id != 3'd2 || rsp_cos != 32'hc0000000 ||
             rsp_sin != 32'h3fffffff || req_ready != '0) bad = 1'b1;
         tick();
      end                           // cycle 28
      chk("bp_stable", bad, 0);
      rsp_ready = 1'b1;
      #1;
      chk("bp_still_valid", rsp_valid, 1);
      tick();                       // cycle 29
      chk("bp_next_grant", req_ready, 4'b1000);
      tick();
      req_valid = '0;
      repeat (22) tick();
      chk("bp_done_idle", busy, 0);

      // round-robin with all requesters valid from reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req_valid = 4'b1111;
      #1;
      wait_grant(n, g);
      chk("rr_first_grant", g, 4'b0001);
      chk("rr_first_wait", n, 0);
      for (int e = 1; e <= 4; e++) begin
         tick();
         wait_grant(n, g);
         exp_grant = 32'd1 << (e % 4);
         chk($sformatf("rr_grant%0d", e), g, exp_grant[N-1:0]);
         chk($sformatf("rr_spacing%0d", e), n + 1, 19);
      end

      // pointer skip: rr_ptr becomes 1, only requester 3 asks
      tick();
      req_valid = 4'b1000;
      wait_grant(n, g);
      chk("skip_grant3", g, 4'b1000);
      chk("skip_spacing", n + 1, 19);
      tick();
      req_valid = 4'b1111;
      wait_grant(n, g);
      chk("skip_ptr_wrap", g, 4'b0001);

      // reset while WAIT counter is 5 (cycle 12 after acceptance)
      tick();
      req_valid = '0;
      repeat (11) tick();
      chk("mid_busy", busy, 1);
      req_valid = 4'b1111;
      reset = 1'b1;
      #1;
      chk("mid_req_ready", req_ready, 4'b0000);
      chk("mid_outs", {rsp_valid, busy, cordic_start}, 0);
      chk("mid_data", {rsp_id, rsp_cos, rsp_sin, cordic_angle}, 0);
      req_valid = '0;
      tick();
      reset = 1'b0;
      bad = 1'b0;
      repeat (25) begin
         tick();
         if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      chk("mid_no_rsp", bad, 0);
      req_valid = 4'b0010;
      #1;
      chk("fresh_ready", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      repeat (17) tick();
      chk("fresh_rsp_valid", rsp_valid, 1);
      chk("fresh_rsp", {rsp_id, rsp_cos, rsp_sin}, {3'd1, 32'h22222222, 32'hdddddddd});

      // latency-1 instance
      req_angle1[0*W +: W] = 32'h12345678;
      req_valid1 = 4'b0001;
      rsp_ready1 = 1'b1;
      #1;
      chk("l1_ready", req_ready1, 4'b0001);
      tick();
      req_valid1 = '0;
      chk("l1_start", cordic_start1, 1);
      tick();
      chk("l1_cycle2", {rsp_valid1, busy1}, 2'b01);
      tick();
      chk("l1_rsp_valid", rsp_valid1, 1);
      chk("l1_rsp", {rsp_id1, rsp_cos1, rsp_sin1}, {3'd0, 32'h12345678, 32'hedcba987});
      tick();
      chk("l1_back_idle", busy1, 0);

      tick();
      chk("core_overlap", overlaps, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
